// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver: 2-flop input synchronizer, tick-paced frame FSM and a
// single holding register with valid/ready handshake plus false-start/framing/parity/overrun status.
module uart_rx_oversampled #(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 tick_16x,
   input  logic                 rx,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int CW = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
   localparam int IW = $clog2(DATA_BITS + 1);
   localparam logic [CW-1:0] HALF_M1  = CW'(OVERSAMPLE / 2 - 1);
   localparam logic [CW-1:0] FULL_M1  = CW'(OVERSAMPLE - 1);
   localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } state_t;

   state_t               state_reg, state_next;
   logic [1:0]           sync_reg;
   logic                 rxs;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic [IW-1:0]        idx_reg, idx_next;
   logic [DATA_BITS-1:0] shift_reg, shift_next;
   logic                 perr_reg, perr_next;
   logic                 good_reg, good_next;
   logic                 bad_reg, bad_next;
   logic [DATA_BITS-1:0] rx_data_reg;
   logic                 rx_valid_reg;
   logic                 parity_err_reg;
   logic                 frame_err_reg;
   logic                 overrun_reg;
   logic                 load;

   // rx is asynchronous to clk; both stages reset to the idle level
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_reg <= 2'b11;
      end else begin
         sync_reg <= {sync_reg[0], rx};
      end
   end

   assign rxs = sync_reg[1];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         idx_reg   <= '0;
         shift_reg <= '0;
         perr_reg  <= 1'b0;
         good_reg  <= 1'b0;
         bad_reg   <= 1'b0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         idx_reg   <= idx_next;
         shift_reg <= shift_next;
         perr_reg  <= perr_next;
         good_reg  <= good_next;
         bad_reg   <= bad_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      shift_next = shift_reg;
      perr_next  = perr_reg;
      good_next  = 1'b0;
      bad_next   = 1'b0;

      case (state_reg)
         IDLE: begin
            if (tick_16x && !rxs) begin
               state_next = START;
               cnt_next   = '0;
            end
         end

         START: begin
            if (tick_16x) begin
               if (cnt_reg == HALF_M1) begin
                  cnt_next = '0;
                  if (rxs) begin
                     state_next = IDLE;
                  end else begin
                     state_next = DATA;
                     idx_next   = '0;
                     perr_next  = 1'b0;
                  end
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end

         DATA: begin
            if (tick_16x) begin
               if (cnt_reg == FULL_M1) begin
                  cnt_next = '0;
                  // Right shift: the first (LSB) bit ends up at bit 0 after DATA_BITS samples
                  shift_next = {rxs, shift_reg[DATA_BITS-1:1]};
                  if (idx_reg == LAST_BIT) begin
                     state_next = PARITY_EN ? PARITY : STOP;
                  end else begin
                     idx_next = idx_reg + IW'(1);
                  end
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end

         PARITY: begin
            if (tick_16x) begin
               if (cnt_reg == FULL_M1) begin
                  cnt_next   = '0;
                  perr_next  = ((^shift_reg) ^ rxs) != PARITY_ODD;
                  state_next = STOP;
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end

         STOP: begin
            if (tick_16x) begin
               if (cnt_reg == FULL_M1) begin
                  cnt_next = '0;
                  if (rxs) begin
                     good_next  = 1'b1;
                     state_next = IDLE;
                  end else begin
                     bad_next   = 1'b1;
                     state_next = BREAK;
                  end
               end else begin
                  cnt_next = cnt_reg + CW'(1);
               end
            end
         end

         BREAK: begin
            // Line must return high before another start can be recognised
            if (rxs) begin
               state_next = IDLE;
               cnt_next   = '0;
            end
         end

         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // The frame result is registered once more, so the handshake decision uses the
   // consumer's rx_ready on the same edge that loads the holding register.
   assign load = good_reg && (!rx_valid_reg || rx_ready);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_data_reg    <= '0;
         rx_valid_reg   <= 1'b0;
         parity_err_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         overrun_reg    <= 1'b0;
      end else begin
         frame_err_reg <= bad_reg;
         overrun_reg   <= good_reg && rx_valid_reg && !rx_ready;
         if (load) begin
            rx_data_reg    <= shift_reg;
            parity_err_reg <= PARITY_EN ? perr_reg : 1'b0;
            rx_valid_reg   <= 1'b1;
         end else if (rx_ready) begin
            rx_valid_reg <= 1'b0;
         end
      end
   end

   assign rx_data    = rx_data_reg;
   assign rx_valid   = rx_valid_reg;
   assign parity_err = parity_err_reg;
   assign frame_err  = frame_err_reg;
   assign overrun    = overrun_reg;
   assign busy       = (state_reg != IDLE);

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: one 8N1 and one 8E1 instance, frames built bit by bit
// from bytes and compared with expectations derived from the frame contents.
module tb_uart_rx_oversampled;

   localparam int OS = 16;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       tick = 1'b0;
   logic       rx_n = 1'b1, ready_n = 1'b0;
   logic       rx_p = 1'b1, ready_p = 1'b0;
   logic [7:0] data_n, data_p;
   logic       valid_n, valid_p, perr_n, perr_p;
   logic       ferr_n, ferr_p, ovr_n, ovr_p, busy_n, busy_p;

   int vectors = 0;
   int miscompares = 0;

   logic [7:0] got_n[$];
   logic [7:0] got_p[$];
   logic       gotpe_n[$];
   logic       gotpe_p[$];
   int         ferr_cnt_n = 0, ovr_cnt_n = 0, vhi_n = 0;
   int         ferr_cnt_p = 0, ovr_cnt_p = 0;

   uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut_n (
      .clk(clk), .rst(rst), .tick_16x(tick), .rx(rx_n),
      .rx_data(data_n), .rx_valid(valid_n), .rx_ready(ready_n),
      .parity_err(perr_n), .frame_err(ferr_n), .overrun(ovr_n), .busy(busy_n)
   );

   uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(OS), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_p (
      .clk(clk), .rst(rst), .tick_16x(tick), .rx(rx_p),
      .rx_data(data_p), .rx_valid(valid_p), .rx_ready(ready_p),
      .parity_err(perr_p), .frame_err(ferr_p), .overrun(ovr_p), .busy(busy_p)
   );

   always #5 clk = ~clk;

   // Oversample enable: one clk out of every four
   initial begin : tick_gen
      int d;
      d = 0;
      forever begin
         @(negedge clk);
         tick = (d == 3);
         d = (d + 1) % 4;
      end
   end

   // Record accepted words and flag pulses away from the active edge
   initial begin : monitor
      forever begin
         @(negedge clk);
         if (valid_n && ready_n) begin
            got_n.push_back(data_n);
            gotpe_n.push_back(perr_n);
         end
         if (valid_p && ready_p) begin
            got_p.push_back(data_p);
            gotpe_p.push_back(perr_p);
         end
         if (valid_n) vhi_n++;
         if (ferr_n) ferr_cnt_n++;
         if (ovr_n) ovr_cnt_n++;
         if (ferr_p) ferr_cnt_p++;
         if (ovr_p) ovr_cnt_p++;
      end
   end

   initial begin : watchdog
      #3ms;
      $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   task automatic wait_ticks(input int n);
      int k;
      k = 0;
      while (k < n) begin
         @(posedge clk);
         if (tick) k++;
      end
   endtask

   task automatic drive_bit(input bit use_p, input logic v, input int nticks);
      #2;
      if (use_p) rx_p = v;
      else rx_n = v;
      wait_ticks(nticks);
   endtask

   task automatic send_frame(input bit use_p, input logic [7:0] b, input bit has_par,
                             input logic pbit, input logic stopb);
      @(posedge clk);
      drive_bit(use_p, 1'b0, OS);
      for (int i = 0; i < 8; i++) drive_bit(use_p, b[i], OS);
      if (has_par) drive_bit(use_p, pbit, OS);
      drive_bit(use_p, stopb, OS);
   endtask

   task automatic clear_mon();
      got_n.delete(); gotpe_n.delete(); got_p.delete(); gotpe_p.delete();
      ferr_cnt_n = 0; ovr_cnt_n = 0; vhi_n = 0; ferr_cnt_p = 0; ovr_cnt_p = 0;
   endtask

   task automatic settle();
      drive_bit(1'b0, 1'b1, 4);
      @(negedge clk);
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      vectors++;
      if ({valid_n, perr_n, ferr_n, ovr_n, busy_n, data_n} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_n: outputs %b, required all zero", {valid_n, perr_n, ferr_n, ovr_n, busy_n, data_n});
      end
      vectors++;
      if ({valid_p, perr_p, ferr_p, ovr_p, busy_p, data_p} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_p: outputs %b, required all zero", {valid_p, perr_p, ferr_p, ovr_p, busy_p, data_p});
      end
      @(posedge clk); #2 rst = 1'b1;
      $display("test_reset done");
   endtask

   task automatic test_basic();
      clear_mon();
      ready_n = 1'b1;
      send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
      settle();
      vectors++;
      if (got_n.size() !== 1 || got_n[0] !== 8'h55 || gotpe_n[0] !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_data: got %0d words first %h, required 1 word 55 perr 0", got_n.size(), (got_n.size() > 0) ? got_n[0] : 8'hxx);
      end
      vectors++;
      if (vhi_n !== 1) begin
         miscompares++;
         $display("FAIL basic_valid_width: rx_valid high %0d clks, required 1", vhi_n);
      end
      vectors++;
      if (busy_n !== 1'b0 || ferr_cnt_n !== 0 || ovr_cnt_n !== 0) begin
         miscompares++;
         $display("FAIL basic_idle: busy %b ferr %0d ovr %0d, required 0 0 0", busy_n, ferr_cnt_n, ovr_cnt_n);
      end
      $display("test_basic done: 0x55");
   endtask

   task automatic test_false_start();
      clear_mon();
      @(posedge clk);
      drive_bit(1'b0, 1'b0, 4);
      drive_bit(1'b0, 1'b1, 16);
      @(negedge clk);
      vectors++;
      if (busy_n !== 1'b0 || got_n.size() !== 0 || ferr_cnt_n !== 0 || ovr_cnt_n !== 0 || vhi_n !== 0) begin
         miscompares++;
         $display("FAIL false_start: busy %b words %0d ferr %0d ovr %0d, required none", busy_n, got_n.size(), ferr_cnt_n, ovr_cnt_n);
      end
      send_frame(1'b0, 8'hA3, 1'b0, 1'b0, 1'b1);
      settle();
      vectors++;
      if (got_n.size() !== 1 || got_n[0] !== 8'hA3) begin
         miscompares++;
         $display("FAIL after_false_start: got %0d words first %h, required A3", got_n.size(), (got_n.size() > 0) ? got_n[0] : 8'hxx);
      end
      $display("test_false_start done");
   endtask

   task automatic test_break();
      clear_mon();
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
      drive_bit(1'b0, 1'b0, 2 * OS);
      @(negedge clk);
      vectors++;
      if (ferr_cnt_n !== 1 || got_n.size() !== 0 || vhi_n !== 0) begin
         miscompares++;
         $display("FAIL break_flag: ferr pulses %0d words %0d, required 1 and 0", ferr_cnt_n, got_n.size());
      end
      vectors++;
      if (busy_n !== 1'b1) begin
         miscompares++;
         $display("FAIL break_hold: busy %b while line low, required 1", busy_n);
      end
      drive_bit(1'b0, 1'b1, 4);
      @(negedge clk);
      vectors++;
      if (busy_n !== 1'b0) begin
         miscompares++;
         $display("FAIL break_exit: busy %b after line high, required 0", busy_n);
      end
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      settle();
      vectors++;
      if (got_n.size() !== 1 || got_n[0] !== 8'h3C || ferr_cnt_n !== 1) begin
         miscompares++;
         $display("FAIL break_recover: got %0d words ferr %0d, required 3C and 1", got_n.size(), ferr_cnt_n);
      end
      $display("test_break done");
   endtask

   task automatic test_overrun();
      clear_mon();
      ready_n = 1'b0;
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
      settle();
      vectors++;
      if (valid_n !== 1'b1 || data_n !== 8'h11) begin
         miscompares++;
         $display("FAIL overrun_hold: valid %b data %h, required 1 11", valid_n, data_n);
      end
      vectors++;
      if (ovr_cnt_n !== 1) begin
         miscompares++;
         $display("FAIL overrun_pulse: %0d pulses, required 1", ovr_cnt_n);
      end
      @(posedge clk); #2 ready_n = 1'b1;
      @(posedge clk); #2 ready_n = 1'b0;
      @(negedge clk);
      vectors++;
      if (valid_n !== 1'b0 || got_n.size() !== 1 || got_n[0] !== 8'h11) begin
         miscompares++;
         $display("FAIL overrun_drain: valid %b words %0d, required 0 and one 11", valid_n, got_n.size());
      end
      $display("test_overrun done");
   endtask

   task automatic test_parity();
      clear_mon();
      ready_p = 1'b1;
      send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
      send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
      settle();
      vectors++;
      if (got_p.size() !== 2 || got_p[0] !== 8'h07 || got_p[1] !== 8'h07) begin
         miscompares++;
         $display("FAIL parity_data: %0d words, required two 07", got_p.size());
      end
      vectors++;
      if (gotpe_p.size() !== 2 || gotpe_p[0] !== 1'b1 || gotpe_p[1] !== 1'b0) begin
         miscompares++;
         $display("FAIL parity_flag: %0d flags first %b second %b, required 1 then 0", gotpe_p.size(),
                  (gotpe_p.size() > 0) ? gotpe_p[0] : 1'bx, (gotpe_p.size() > 1) ? gotpe_p[1] : 1'bx);
      end
      $display("test_parity done");
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] b;
      clear_mon();
      ready_n = 1'b0;
      send_frame(1'b0, 8'h9A, 1'b0, 1'b0, 1'b1);
      settle();
      vectors++;
      if (valid_n !== 1'b1 || data_n !== 8'h9A) begin
         miscompares++;
         $display("FAIL premid_load: valid %b data %h, required 1 9A", valid_n, data_n);
      end
      b = 8'hF0;
      @(posedge clk);
      drive_bit(1'b0, 1'b0, OS);
      for (int i = 0; i < 4; i++) drive_bit(1'b0, b[i], OS);
      drive_bit(1'b0, b[4], OS / 2);
      #2 rst = 1'b0;
      #1;
      vectors++;
      if ({valid_n, perr_n, ferr_n, ovr_n, busy_n, data_n} !== 13'd0) begin
         miscompares++;
         $display("FAIL reset_mid: outputs %b, required all zero", {valid_n, perr_n, ferr_n, ovr_n, busy_n, data_n});
      end
      rx_n = 1'b1;
      repeat (4) @(posedge clk);
      #2 rst = 1'b1;
      ready_n = 1'b1;
      clear_mon();
      send_frame(1'b0, 8'hF0, 1'b0, 1'b0, 1'b1);
      settle();
      vectors++;
      if (got_n.size() !== 1 || got_n[0] !== 8'hF0 || ferr_cnt_n !== 0 || ovr_cnt_n !== 0) begin
         miscompares++;
         $display("FAIL reset_recover: %0d words ferr %0d ovr %0d, required F0 no flags", got_n.size(), ferr_cnt_n, ovr_cnt_n);
      end
      $display("test_reset_mid_frame done");
   endtask

   task automatic test_random();
      logic [7:0] exp_n[$];
      logic [7:0] exp_p[$];
      logic       exppe_p[$];
      logic [7:0] b;
      logic       pb;
      clear_mon();
      ready_n = 1'b1;
      ready_p = 1'b1;
      for (int k = 0; k < 8; k++) begin
         b = 8'($urandom_range(0, 255));
         exp_n.push_back(b);
         send_frame(1'b0, b, 1'b0, 1'b0, 1'b1);
         $display("random 8N1 frame %0d: %h", k, b);
      end
      for (int k = 0; k < 8; k++) begin
         b = 8'($urandom_range(0, 255));
         pb = 1'($urandom_range(0, 1));
         exp_p.push_back(b);
         // Even parity: error when the total count of ones in data plus parity bit is odd
         exppe_p.push_back(1'(($countones(b) + int'(pb)) % 2));
         send_frame(1'b1, b, 1'b1, pb, 1'b1);
         $display("random 8E1 frame %0d: %h parity bit %b", k, b, pb);
      end
      settle();
      vectors++;
      if (got_n.size() !== exp_n.size()) begin
         miscompares++;
         $display("FAIL random_n_count: %0d words, required %0d", got_n.size(), exp_n.size());
      end else begin
         for (int k = 0; k < exp_n.size(); k++) begin
            vectors++;
            if (got_n[k] !== exp_n[k] || gotpe_n[k] !== 1'b0) begin
               miscompares++;
               $display("FAIL random_n[%0d]: got %h perr %b, required %h perr 0", k, got_n[k], gotpe_n[k], exp_n[k]);
            end
         end
      end
      vectors++;
      if (got_p.size() !== exp_p.size()) begin
         miscompares++;
         $display("FAIL random_p_count: %0d words, required %0d", got_p.size(), exp_p.size());
      end else begin
         for (int k = 0; k < exp_p.size(); k++) begin
            vectors++;
            if (got_p[k] !== exp_p[k] || gotpe_p[k] !== exppe_p[k]) begin
               miscompares++;
               $display("FAIL random_p[%0d]: got %h perr %b, required %h perr %b", k, got_p[k], gotpe_p[k], exp_p[k], exppe_p[k]);
            end
         end
      end
      vectors++;
      if (ferr_cnt_n !== 0 || ovr_cnt_n !== 0 || ferr_cnt_p !== 0 || ovr_cnt_p !== 0) begin
         miscompares++;
         $display("FAIL random_flags: ferr %0d/%0d ovr %0d/%0d, required all 0", ferr_cnt_n, ferr_cnt_p, ovr_cnt_n, ovr_cnt_p);
      end
   endtask

   initial begin : main
      test_reset();
      test_basic();
      test_false_start();
      test_break();
      test_overrun();
      test_parity();
      test_reset_mid_frame();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
